mc_control_unit: RTL
====================

# mc_control_unit

Multicycle control unit for the ARM core: a Moore state machine plus condition/flag logic. It sequences the shared-memory multicycle datapath (PC, instruction register, register file, ALU, memory port) across 3–5 cycles per instruction. It drives every enable and mux select of that datapath and holds the architectural NZCV flags.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S/L
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- PCWrite  out  1  PC register enable
- MemWrite  out  1  data memory write strobe
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- RegSrc  out  2  [0]=1 for branch (RA1=R15); [1]=1 for store (RA2=Rd)
- ALUSrcA  out  1  0=Rn, 1=PC
- ALUSrcB  out  2  00=register, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  out  2  equals Op
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV(pass SrcB)
- Flags  out  4  registered {N,Z,C,V}
- State  out  4  current state encoding (debug)

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECR=6, EXECI=7, ALUWB=8, BRANCH=9
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=00,I=0→EXECR; Op=00,I=1→EXECI; Op=01→MEMADR; Op=10→BRANCH; Op=11→FETCH (undefined; no side effects).
  - MEMADR: L=1→MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH. MEMWR→FETCH. EXECR/EXECI→ALUWB→FETCH. BRANCH→FETCH.
  - Encodings 10–15→FETCH.
- Outputs per state (unlisted selects = 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 (unconditional).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10 (PC+8 for R15 reads).
  - MEMADR: ALUSrcB=01, ALUControl=ADD if Funct[3] (U) else SUB.
  - MEMRD, MEMWR: AdrSrc=1. MEMWR also drives MemWrite=CondEx.
  - MEMWB: ResultSrc=01, RegWrite=CondEx; PCWrite=CondEx if Rd=15.
  - EXECR: ALUSrcB=00. EXECI: ALUSrcB=01. ALUControl comes from cmd in both.
  - ALUWB: ResultSrc=00; RegWrite=CondEx & !NoWrite; PCWrite=CondEx & !NoWrite if Rd=15.
  - BRANCH: ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=CondEx.
- cmd decode:
  - 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR, 1101→MOV.
  - 1010 (CMP)→SUB with NoWrite=1.
  - Any other cmd→ADD with NoWrite=1.
- RegSrc[0]=(Op=10); RegSrc[1]=(Op=01).
- CondEx is evaluated against the registered Flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N=V, LT N≠V, GT !Z&(N=V), LE Z|(N≠V)
  - AL 1; 1111→0
- Flag update happens at the clock edge ending EXECR/EXECI, only if CondEx & S:
  - N,Z always load.
  - C,V load only for ADD/SUB/CMP; they hold for logical/MOV.
- A failed condition still walks the full state path; only the writes are suppressed.

## Timing
- Reset:
  - State=FETCH, Flags=0000.
  - While reset=1, PCWrite, MemWrite, RegWrite and IRWrite are forced 0; selects show FETCH values.
  - Reset asserted mid-instruction aborts the instruction; no writes occur in that cycle.
- Outputs are combinational from State, Flags and the instruction fields (Moore plus condition gating); no extra registered delay.
- Latency in cycles, FETCH→FETCH:
  - branch 3, data-processing 4, STR 4, LDR 5, undefined 2.
- Instruction fields are sampled from the IR and stay stable from DECODE onward.
- Flags written by an instruction are visible to CondEx of the next instruction from its DECODE cycle.

## Test plan
- Reset held 2 cycles, then released:
  - State=0, Flags=0000, all write enables 0 during reset.
  - First post-reset cycle shows IRWrite=1, PCWrite=1.
- ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000):
  - States 0→1→6→8→0.
  - RegWrite=1 only in ALUWB; ALUControl=000 in EXECR.
- CMP with S=1 and ALUFlags=0100, then BEQ (Cond=0000, Op=10):
  - Flags=0100 after EXECR.
  - Branch path 0→1→9→0 with PCWrite=1 in BRANCH.
- Same BEQ with Flags=0000: PCWrite=0 in BRANCH; states unchanged.
- LDR (Op=01, L=1, U=1):
  - 0→1→2→3→4→0; AdrSrc=1 in MEMRD; RegWrite=1 in MEMWB.
  - With Rd=15, PCWrite=1 in MEMWB.
- STR with Cond=0001 and Z=1:
  - MemWrite=0 in MEMWR; 4-cycle path.
  - Op=11 returns to FETCH after DECODE with no write.

Source files
------------

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle ARM control FSM with condition evaluation and NZCV flag register.
module mc_control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] RegSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic [3:0] Flags,
   output logic [3:0] State
);

   localparam int unsigned STATE_W = 4;
   localparam int unsigned ALUC_W  = 3;

   localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALUC_W-1:0] ALU_ORR = 3'b011;
   localparam logic [ALUC_W-1:0] ALU_MOV = 3'b100;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   state_t              state_q;
   state_t              state_d;
   state_t              state_eff;
   logic [3:0]          flags_q;
   logic [ALUC_W-1:0]   cmd_alu;
   logic                no_write;
   logic                cond_ex;
   logic                flag_upd;
   logic                cmd_arith;
   logic                n_f, z_f, c_f, v_f;

   assign {n_f, z_f, c_f, v_f} = flags_q;
   assign Flags     = flags_q;
   assign State     = STATE_W'(state_q);
   assign ImmSrc    = Op;
   assign RegSrc    = {Op == 2'b01, Op == 2'b10};
   assign cmd_arith = (cmd_alu == ALU_ADD) || (cmd_alu == ALU_SUB);
   assign flag_upd  = ((state_q == S_EXECR) || (state_q == S_EXECI)) && cond_ex && Funct[0];

   // State and flag registers; flags capture the ALU result at the end of an execute cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         if (flag_upd) begin
            flags_q[3:2] <= ALUFlags[3:2];
            if (cmd_arith) flags_q[1:0] <= ALUFlags[1:0];
         end
      end
   end

   // Next-state decode
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXECR,
         S_EXECI:  state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // Data-processing cmd to ALU operation; NoWrite marks compares and unsupported commands
   always_comb begin
      cmd_alu  = ALU_ADD;
      no_write = 1'b0;
      case (Funct[4:1])
         4'b0100: cmd_alu = ALU_ADD;
         4'b0010: cmd_alu = ALU_SUB;
         4'b0000: cmd_alu = ALU_AND;
         4'b1100: cmd_alu = ALU_ORR;
         4'b1101: cmd_alu = ALU_MOV;
         4'b1010: begin
            cmd_alu  = ALU_SUB;
            no_write = 1'b1;
         end
         default: begin
            cmd_alu  = ALU_ADD;
            no_write = 1'b1;
         end
      endcase
   end

   // Condition check against the architectural flags
   always_comb begin
      cond_ex = 1'b0;
      case (Cond)
         4'b0000: cond_ex = z_f;
         4'b0001: cond_ex = !z_f;
         4'b0010: cond_ex = c_f;
         4'b0011: cond_ex = !c_f;
         4'b0100: cond_ex = n_f;
         4'b0101: cond_ex = !n_f;
         4'b0110: cond_ex = v_f;
         4'b0111: cond_ex = !v_f;
         4'b1000: cond_ex = c_f && !z_f;
         4'b1001: cond_ex = !c_f || z_f;
         4'b1010: cond_ex = (n_f == v_f);
         4'b1011: cond_ex = (n_f != v_f);
         4'b1100: cond_ex = !z_f && (n_f == v_f);
         4'b1101: cond_ex = z_f || (n_f != v_f);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Per-state datapath controls; reset shows FETCH selects with every write suppressed
   always_comb begin
      state_eff  = reset ? S_FETCH : state_q;
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = ALU_ADD;
      case (state_eff)
         S_FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_MEMADR: begin
            ALUSrcB    = 2'b01;
            ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
         end
         S_MEMRD:  AdrSrc = 1'b1;
         S_MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = cond_ex;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = cond_ex;
            PCWrite   = cond_ex && (Rd == 4'd15);
         end
         S_EXECR:  ALUControl = cmd_alu;
         S_EXECI: begin
            ALUSrcB    = 2'b01;
            ALUControl = cmd_alu;
         end
         S_ALUWB: begin
            RegWrite = cond_ex && !no_write;
            PCWrite  = cond_ex && !no_write && (Rd == 4'd15);
         end
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            PCWrite   = cond_ex;
         end
         default: ;
      endcase
      if (reset) begin
         PCWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         IRWrite  = 1'b0;
      end
   end

endmodule
